// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter
//   Two-requester arbiter in front of a bank of four registers. The owner
//   drives a one-hot register enable, a shared FunSel bus and a shared data
//   bus. Ties from IDLE go to whichever side was not granted most recently.
//   On release, the grant passes straight to a waiting requester with no
//   idle gap.
//
//   Optional feature, guarded by macro REG_ARB_TIMEOUT_EN:
//     hold watchdog. After MAX_HOLD consecutive grant cycles, the grant is
//     forced over to a waiting requester, and Preempt pulses for one cycle.
//     Without the macro there is no counter, Preempt is tied to 0, and a
//     grant is held for as long as its request stays high.
//
// Parameters
//   DATA_W    register data path width
//   MAX_HOLD  consecutive grant cycles before preemption (2..255)
//
// Ports
//   Clock                 rising-edge clock
//   Reset                 asynchronous active-low reset
//   ReqA/ReqB             access requests
//   SelA/SelB [1:0]       target register index
//   OpA/OpB [2:0]         FunSel code for the target register
//   DataA/DataB           load data for the target register
//   GntA/GntB             grant, decoded from the state register
//   RegE [3:0]            one-hot register enable (owner with request high)
//   RegFunSel [2:0]       owner's FunSel, 0 when idle
//   RegI                  owner's data, 0 when idle
//   Preempt               one-cycle pulse on a forced grant switch
//   state_dbg [1:0]       current FSM state (00 IDLE, 01 OWN_A, 10 OWN_B)
//
// Handshake: a requester holds ReqX high for as long as it needs the
// registers. GntX marks ownership. A register operation happens in every
// cycle where GntX and ReqX are both high, using that cycle's SelX/OpX/DataX.
module reg_access_arbiter #(
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ReqA,
    input  logic              ReqB,
    input  logic [1:0]        SelA,
    input  logic [1:0]        SelB,
    input  logic [2:0]        OpA,
    input  logic [2:0]        OpB,
    input  logic [DATA_W-1:0] DataA,
    input  logic [DATA_W-1:0] DataB,
    output logic              GntA,
    output logic              GntB,
    output logic [3:0]        RegE,
    output logic [2:0]        RegFunSel,
    output logic [DATA_W-1:0] RegI,
    output logic              Preempt,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_b;       // 1: B was granted most recently
    logic   last_b_next;
    logic   hold_expired; // owner has used up its MAX_HOLD cycles

`ifdef REG_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt;
    logic       preempt_next;

    assign hold_expired = (hold_cnt == HOLD_LIM);

    // A forced switch happens only while the owner still wants the bus.
    // A voluntary release is an ordinary handover.
    assign preempt_next = hold_expired &&
                          (((state == OWN_A) && ReqA && ReqB) ||
                           ((state == OWN_B) && ReqB && ReqA));

    // The counter restarts on any state change. It saturates at HOLD_LIM,
    // so an owner with no competitor keeps the grant.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hold_cnt <= 8'd0;
            Preempt  <= 1'b0;
        end else begin
            Preempt <= preempt_next;
            if (state_next != state) begin
                hold_cnt <= 8'd0;
            end else if ((state != IDLE) && !hold_expired) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end
`else
    assign hold_expired = 1'b0;
    assign Preempt      = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            last_b <= 1'b1;
        end else begin
            state  <= state_next;
            last_b <= last_b_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ReqA && ReqB) begin
                    state_next = last_b ? OWN_A : OWN_B;
                end else if (ReqA) begin
                    state_next = OWN_A;
                end else if (ReqB) begin
                    state_next = OWN_B;
                end
            end
            OWN_A: begin
                if (!ReqA) begin
                    state_next = ReqB ? OWN_B : IDLE;
                end else if (hold_expired && ReqB) begin
                    state_next = OWN_B;
                end
            end
            OWN_B: begin
                if (!ReqB) begin
                    state_next = ReqA ? OWN_A : IDLE;
                end else if (hold_expired && ReqA) begin
                    state_next = OWN_A;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        last_b_next = last_b;
        if (state_next == OWN_A) begin
            last_b_next = 1'b0;
        end else if (state_next == OWN_B) begin
            last_b_next = 1'b1;
        end
    end

    // Register-side outputs follow the live request and select inputs.
    // Because of this, a mid-grant change takes effect in the same cycle,
    // and reset drops RegE as soon as it forces IDLE.
    always_comb begin
        GntA      = (state == OWN_A);
        GntB      = (state == OWN_B);
        RegE      = 4'b0000;
        RegFunSel = 3'b000;
        RegI      = '0;
        case (state)
            OWN_A: begin
                RegFunSel = OpA;
                RegI      = DataA;
                if (ReqA) RegE = 4'b0001 << SelA;
            end
            OWN_B: begin
                RegFunSel = OpB;
                RegI      = DataB;
                if (ReqB) RegE = 4'b0001 << SelB;
            end
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_reg_access_arbiter.sv
module tb_reg_access_arbiter;

    localparam int DATA_W = 16;
    localparam int MH     = 4;
`ifdef REG_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req_a, req_b;
    logic [1:0]        sel_a, sel_b;
    logic [2:0]        op_a, op_b;
    logic [DATA_W-1:0] data_a, data_b;
    logic              gnt_a, gnt_b, preempt;
    logic [3:0]        reg_e;
    logic [2:0]        reg_funsel;
    logic [DATA_W-1:0] reg_i;
    logic [1:0]        state_dbg;

    reg_access_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MH)) dut (
        .Clock(clock), .Reset(reset_n),
        .ReqA(req_a), .ReqB(req_b), .SelA(sel_a), .SelB(sel_b),
        .OpA(op_a), .OpB(op_b), .DataA(data_a), .DataB(data_b),
        .GntA(gnt_a), .GntB(gnt_b), .RegE(reg_e), .RegFunSel(reg_funsel),
        .RegI(reg_i), .Preempt(preempt), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: owner 0 = nobody, 1 = A, 2 = B; held = cycles of the
    // current grant so far (1 on the first granted cycle).
    int   m_owner, m_last, m_held;
    bit   m_pre;
    logic [2:0] exp_q[$];  // {gnt_a, gnt_b, preempt} expected after each edge

    task automatic model_reset();
        m_owner = 0;
        m_last  = 2;
        m_held  = 0;
        m_pre   = 1'b0;
        exp_q.delete();
        exp_q.push_back(3'b000);
    endtask

    task automatic model_step();
        int  other, nxt;
        bit  own_req, oth_req;
        other   = (m_owner == 1) ? 2 : 1;
        own_req = (m_owner == 1) ? req_a : req_b;
        oth_req = (m_owner == 1) ? req_b : req_a;
        m_pre   = 1'b0;
        if (m_owner == 0) begin
            if (req_a && req_b) nxt = (m_last == 2) ? 1 : 2;
            else if (req_a)     nxt = 1;
            else if (req_b)     nxt = 2;
            else                nxt = 0;
        end else if (!own_req) begin
            nxt = oth_req ? other : 0;
        end else if (TO_EN && m_held >= MH && oth_req) begin
            nxt   = other;
            m_pre = 1'b1;
        end else begin
            nxt = m_owner;
        end
        if (nxt == 0)            m_held = 0;
        else if (nxt == m_owner) m_held++;
        else begin
            m_held = 1;
            m_last = nxt;
        end
        m_owner = nxt;
        exp_q.push_back({m_owner == 1, m_owner == 2, m_pre});
    endtask

    task automatic check_regs();
        logic [2:0] e;
        check_val("sb_depth", exp_q.size(), 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
        check_val("gnt_a", gnt_a, e[2]);
        check_val("gnt_b", gnt_b, e[1]);
        check_val("preempt", preempt, e[0]);
        check_val("rege_onehot0", $onehot0(reg_e), 1);
        check_val("gnt_excl", gnt_a & gnt_b, 0);
    endtask

    task automatic check_comb();
        logic [3:0]        e;
        logic [2:0]        fs;
        logic [DATA_W-1:0] d;
        e = 4'b0; fs = 3'b0; d = '0;
        if (m_owner == 1) begin
            fs = op_a; d = data_a;
            if (req_a) e[sel_a] = 1'b1;
        end else if (m_owner == 2) begin
            fs = op_b; d = data_b;
            if (req_b) e[sel_b] = 1'b1;
        end
        check_val("reg_e", reg_e, e);
        check_val("reg_funsel", reg_funsel, fs);
        check_val("reg_i", reg_i, d);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit ra, input bit rb, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [2:0] oa, input logic [2:0] ob,
                         input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] db);
        req_a = ra; req_b = rb; sel_a = sa; sel_b = sb;
        op_a = oa; op_b = ob; data_a = da; data_b = db;
        #1 check_comb();
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_regs();
        check_comb();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        check_comb();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_val("rst_hold_gnt_a", gnt_a, 0);
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        req_a = 0; req_b = 0; sel_a = 0; sel_b = 0;
        op_a = 0; op_b = 0; data_a = 0; data_b = 0;
        #2;
        do_reset();

        // Single request from IDLE: grant one cycle later.
        drive(1, 0, 2'd2, 2'd0, 3'b010, 3'b000, 16'h1234, 16'h0000);
        check_val("t032_pre_gnt", gnt_a, 0);
        cycle();
        check_val("t032_gnt", gnt_a, 1);
        check_val("t032_rege", reg_e, 4'b0100);
        check_val("t032_regi", reg_i, 16'h1234);
        check_val("t032_fs", reg_funsel, 3'b010);
        // A mid-grant select/data change is visible in the same cycle.
        drive(1, 0, 2'd3, 2'd0, 3'b101, 3'b000, 16'hbeef, 16'h0000);
        check_val("t023_rege", reg_e, 4'b1000);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Tie after reset goes to A, then the next tie goes to B.
        do_reset();
        drive(1, 1, 2'd1, 2'd2, 3'b001, 3'b110, 16'h1111, 16'h2222);
        cycle();
        check_val("t033_first_a", gnt_a, 1);
        drive(0, 0, 2'd1, 2'd2, 3'b001, 3'b110, 16'h1111, 16'h2222);
        cycle();
        drive(1, 1, 2'd1, 2'd2, 3'b001, 3'b110, 16'h1111, 16'h2222);
        cycle();
        check_val("t033_second_b", gnt_b, 1);

        // Handover A -> B with no idle gap.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 0, 2'd0, 2'd3, 3'b011, 3'b100, 16'haaaa, 16'h5555);
        cycle();
        drive(1, 1, 2'd0, 2'd3, 3'b011, 3'b100, 16'haaaa, 16'h5555);
        cycle();
        drive(0, 1, 2'd0, 2'd3, 3'b011, 3'b100, 16'haaaa, 16'h5555);
        cycle();
        check_val("t034_gnt_a", gnt_a, 0);
        check_val("t034_gnt_b", gnt_b, 1);
        check_val("t034_rege", reg_e, 4'b1000);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        drive(1, 0, 2'd0, 2'd1, 3'b001, 3'b010, 16'h0a0a, 16'h0b0b);
        cycle();
`ifdef REG_ARB_TIMEOUT_EN
        // B is raised in the first grant cycle; A is preempted after MH cycles.
        drive(1, 1, 2'd0, 2'd1, 3'b001, 3'b010, 16'h0a0a, 16'h0b0b);
        repeat (MH - 1) cycle();
        check_val("t035_still_a", gnt_a, 1);
        cycle();
        check_val("t035_gnt_b", gnt_b, 1);
        check_val("t035_preempt", preempt, 1);
        cycle();
        check_val("t035_pulse_end", preempt, 0);
`else
        // Without the watchdog, A keeps the grant indefinitely.
        drive(1, 1, 2'd0, 2'd1, 3'b001, 3'b010, 16'h0a0a, 16'h0b0b);
        repeat (300) cycle();
        check_val("t037_gnt_a", gnt_a, 1);
        check_val("t037_preempt", preempt, 0);
`endif

        // Asynchronous reset in the middle of a grant.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 0, 2'd0, 2'd0, 3'b111, 3'b000, 16'hc0de, 16'h0000);
        cycle();
        check_val("t036_rege_before", reg_e, 4'b0001);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("t036_rege_async", reg_e, 4'b0000);
        check_val("t036_gnt_async", gnt_a, 0);
        do_reset();
        cycle();
        check_val("t036_regrant", gnt_a, 1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  DATA_W'($urandom), DATA_W'($urandom));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_access_arbiter.md
REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of the register data path.
REQ-002 SHALL have parameter MAX_HOLD, default 8, the maximum number of consecutive grant cycles before preemption (legal range 2..255).
REQ-003 SHALL have port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have ports ReqA / ReqB, input, 1 each, access request from requester A / B.
REQ-006 SHALL have ports SelA / SelB, input, 2 each, target register index 0..3.
REQ-007 SHALL have ports OpA / OpB, input, 3 each, FunSel code forwarded to the target register.
REQ-008 SHALL have ports DataA / DataB, input, DATA_W each, load data forwarded to the target register.
REQ-009 SHALL have ports GntA / GntB, output, 1 each, registered grant.
REQ-010 SHALL have port RegE, output, 4, one-hot enable to registers 0..3.
REQ-011 SHALL have port RegFunSel, output, 3, shared FunSel bus to all four registers.
REQ-012 SHALL have port RegI, output, DATA_W, shared data bus to all four registers.
REQ-013 SHALL have port Preempt, output, 1, one-cycle pulse marking a forced grant switch.

Function
REQ-014 SHALL implement states IDLE, OWN_A and OWN_B, with GntA=1 only in OWN_A, GntB=1 only in OWN_B, and both 0 in IDLE.
REQ-015 SHALL, in IDLE with exactly one request high, enter that requester's OWN state at the next edge, giving a 1-cycle grant latency.
REQ-016 SHALL, in IDLE with both requests high, grant the requester not granted most recently, with the LastGnt pointer set to B at reset so A wins the first tie.
REQ-017 SHALL, in OWN_X, remain in OWN_X while ReqX=1 and no preemption applies.
REQ-018 SHALL, in OWN_X when ReqX=0 is sampled, move to OWN_other if the other request is high, otherwise to IDLE, with no idle gap on handover.
REQ-019 SHALL drive RegE, RegFunSel and RegI combinationally: RegE = onehot(SelX) only when GntX=1 and ReqX=1, otherwise 4'b0000.
REQ-020 SHALL drive RegFunSel = OpX and RegI = DataX from the owner, and drive 0 on both in IDLE.
REQ-021 SHALL never assert RegE with more than one bit set, never assert GntA and GntB together, and never drive RegE for the non-owner.
REQ-022 SHALL update LastGnt on every entry to OWN_A or OWN_B.
REQ-023 SHALL treat changes to SelX, OpX or DataX mid-grant as effective in the same cycle, with no re-arbitration.

Reset
REQ-024 SHALL, on Reset=0, immediately and asynchronously force IDLE, LastGnt=B, hold counter=0 and Preempt=0, which drives GntA, GntB, RegE, RegFunSel and RegI to 0.
REQ-025 SHALL, if reset asserts mid-grant, drop RegE in the same cycle so no register operation completes after assertion.
REQ-026 SHALL, after Reset returns to 1, resume arbitration on the first rising edge.

Configuration
REQ-027 SHALL compile the hold watchdog only when macro REG_ARB_TIMEOUT_EN is defined.
REQ-028 SHALL, with REG_ARB_TIMEOUT_EN defined, clear an 8-bit hold counter on entry to OWN_X and increment it on each cycle in OWN_X.
REQ-029 SHALL, with REG_ARB_TIMEOUT_EN defined, switch to OWN_other and pulse Preempt=1 for one cycle at the next edge when the counter equals MAX_HOLD-1 and the other request is high.
REQ-030 SHALL, with REG_ARB_TIMEOUT_EN defined, saturate the counter and keep the grant when the counter equals MAX_HOLD-1 and the other request is low.
REQ-031 SHALL, without REG_ARB_TIMEOUT_EN, contain no counter, tie Preempt to 0, and hold a grant indefinitely while ReqX=1.

Verification
REQ-032 SHALL cover: ReqA=1, SelA=2, OpA=3'b010, DataA=16'h1234 from IDLE -> GntA=1 one cycle later, RegE=4'b0100, RegI=16'h1234, RegFunSel=3'b010.
REQ-033 SHALL cover: ReqA and ReqB rising together after reset -> A granted; both re-request after release -> B granted.
REQ-034 SHALL cover: in OWN_A, ReqA falls while ReqB=1 -> GntA=0 and GntB=1 on the same edge, with RegE never showing two bits.
REQ-035 SHALL cover: REG_ARB_TIMEOUT_EN defined, MAX_HOLD=4, ReqA held, ReqB raised at cycle 1 of the grant -> after 4 grant cycles GntB=1 and Preempt pulses for one cycle.
REQ-036 SHALL cover: Reset pulled low mid-grant with RegE=4'b0001 -> RegE=0 and GntA=0 immediately, then A re-granted one cycle after release if ReqA=1.
REQ-037 SHALL cover: macro undefined, ReqA held for 300 cycles with ReqB=1 -> GntA stays 1 and Preempt stays 0 throughout.
